mem_interface: RTL and testbench
================================

Name: mem_interface

Overview:
- Sits directly downstream of the CPU's memory-control outputs (MemRead, MemWrite, SWB, address, store data) and between the CPU and an external variable-latency word RAM.
- Latches each CPU access and drives a req/ack handshake to memory.
- Generates byte-lane enables for store-byte and returns read data.
- Holds the CPU in stall until the access completes, errors out, or times out.

Parameters:
- ADDR_W, 32, address width on CPU and memory sides
- DATA_W, 32, data width; fixed at 32 because byte lanes are hard-wired to 4
- TIMEOUT, 15, maximum cycles to wait for mem_ack before aborting (1..255)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_read  in  1  read request (MemRead), level, sampled in IDLE
- cpu_write  in  1  write request (MemWrite), level, sampled in IDLE
- cpu_swb  in  1  store-byte qualifier for cpu_write
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  store data; byte store uses bits [7:0]
- cpu_rdata  out  DATA_W  registered read data
- cpu_stall  out  1  CPU must hold its state and request while high
- cpu_err  out  1  one-cycle pulse: misaligned, conflicting, or timed-out access
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write, 0 = read
- mem_be  out  4  byte-lane enables
- mem_addr  out  ADDR_W  word address; bits [1:0] are always 0
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe

Behaviour:
- Reset (reset=0, asynchronous) forces the following, and the outputs hold these values until the first request:
  - state = IDLE
  - mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0
  - cpu_rdata = 0, cpu_err = 0, timeout counter = 0
- Reset asserted mid-transaction drops mem_req immediately. Any mem_ack arriving after that is ignored.
- States:
  - IDLE
  - CHECK: one cycle. Latches the request and validates it.
  - ACCESS: mem_req=1, waiting for mem_ack.
  - DONE: one cycle, completion.
  - ERROR: one cycle. cpu_err=1.
- IDLE -> CHECK when cpu_read or cpu_write is 1. The block latches addr, wdata, swb and the direction.
- CHECK goes to ERROR when any of these holds:
  - cpu_read and cpu_write are both 1
  - word write (cpu_swb=0) with addr[1:0] != 0
- Otherwise CHECK -> ACCESS.
- Reads ignore addr[1:0]: mem_addr = {addr[ADDR_W-1:2],2'b00}, mem_be=4'b1111.
- Word write: mem_be=4'b1111, mem_wdata = wdata.
- Byte write: mem_be = 4'b0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}.
- ACCESS drives mem_req, mem_we, mem_be, mem_addr and mem_wdata from registers. They must be stable for the whole of ACCESS.
- On mem_ack in ACCESS:
  - cpu_rdata <= mem_rdata on reads; cpu_rdata is unchanged on writes.
  - Go to DONE. mem_req drops on the cycle after the ack.
- Timeout: the counter clears on entry to ACCESS and increments each ACCESS cycle without ack. When it reaches TIMEOUT: ACCESS -> ERROR, mem_req drops, and cpu_rdata is unchanged.
- An ack arriving on the same cycle the counter reaches TIMEOUT counts as success; ack wins.
- DONE -> IDLE and ERROR -> IDLE unconditionally.
- cpu_stall is combinational:
  - 1 when state is CHECK or ACCESS
  - 1 in IDLE while a request is present
  - 0 in DONE, ERROR, and idle-without-request
- Minimum read latency: request seen in IDLE; CHECK; ACCESS with ack in the same cycle; DONE. That gives 3 cycles of stall before the CPU proceeds, with cpu_rdata valid in DONE and held afterwards.
- mem_ack outside ACCESS is ignored.
- The CPU holds its request until stall falls. A request still high in IDLE after DONE starts a new transaction, so the CPU must drop it in DONE.

Test Plan:
1. Word read, ack on 2nd ACCESS cycle: cpu_addr=0x0000_0104, mem_rdata=0xDEADBEEF -> mem_addr=0x104, mem_be=1111, mem_we=0; cpu_stall high 4 cycles; cpu_rdata=0xDEADBEEF in DONE.
2. Byte store: cpu_addr=0x0000_0203, cpu_wdata=0x1234_56A5, cpu_swb=1 -> mem_addr=0x200, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1; cpu_rdata unchanged.
3. Misaligned word write: cpu_addr=0x0000_0002 -> ERROR, cpu_err=1 for one cycle, mem_req never asserted.
4. Read and write both asserted -> cpu_err pulse, no mem_req, return to IDLE.
5. Timeout with TIMEOUT=15 and no ack -> mem_req high exactly 15 cycles, then cpu_err pulse. A late ack after that is ignored and the state stays IDLE.
6. Reset asserted mid-ACCESS -> mem_req=0 asynchronously (before the next clk edge); all outputs at reset values. After release, a fresh read completes normally.

Source files
------------

// File: rtl/mem_interface_if.sv
// CPU-side and memory-side signal bundle for mem_interface.
// The slave modport is the bridge's own view; master is the CPU/RAM side.
interface mem_interface_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              cpu_read;
   logic              cpu_write;
   logic              cpu_swb;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   logic              cpu_err;
   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport slave (
      input  cpu_read, cpu_write, cpu_swb, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
      output cpu_rdata, cpu_stall, cpu_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output cpu_read, cpu_write, cpu_swb, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
      input  cpu_rdata, cpu_stall, cpu_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_interface.sv
// Latches one CPU load/store, runs a req/ack handshake to a variable-latency word RAM
// and stalls the CPU until the access completes, is rejected, or times out.
module mem_interface #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input logic            clk,
   input logic            reset,
   mem_interface_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StCheck, StAccess, StDone, StError} state_e;

   localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

   state_e            r_state;
   logic              r_rd;
   logic              r_wr;
   logic              r_swb;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [7:0]        r_cnt;

   logic              r_mem_req;
   logic              r_mem_we;
   logic [3:0]        r_mem_be;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic              r_cpu_err;

   logic w_req;
   logic w_bad;

   assign w_req = bus.cpu_read | bus.cpu_write;

   // Conflicting direction, or a word store that is not word aligned.
   assign w_bad = (r_rd && r_wr) || (r_wr && !r_swb && (r_addr[1:0] != 2'b00));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= StIdle;
         r_rd        <= 1'b0;
         r_wr        <= 1'b0;
         r_swb       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= 4'b0000;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cpu_rdata <= '0;
         r_cpu_err   <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_req) begin
                  r_rd    <= bus.cpu_read;
                  r_wr    <= bus.cpu_write;
                  r_swb   <= bus.cpu_swb;
                  r_addr  <= bus.cpu_addr;
                  r_wdata <= bus.cpu_wdata;
                  r_state <= StCheck;
               end
            end
            StCheck: begin
               if (w_bad) begin
                  r_cpu_err <= 1'b1;
                  r_state   <= StError;
               end else begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= r_wr;
                  r_mem_addr  <= {r_addr[ADDR_W-1:2], 2'b00};
                  r_mem_be    <= (r_wr && r_swb) ? (4'b0001 << r_addr[1:0]) : 4'b1111;
                  r_mem_wdata <= (r_wr && r_swb) ? {4{r_wdata[7:0]}} : r_wdata;
                  r_cnt       <= '0;
                  r_state     <= StAccess;
               end
            end
            StAccess: begin
               // Ack takes priority over a timeout expiring in the same cycle.
               if (bus.mem_ack) begin
                  if (!r_wr) begin
                     r_cpu_rdata <= bus.mem_rdata;
                  end
                  r_mem_req <= 1'b0;
                  r_state   <= StDone;
               end else if (r_cnt == CntLast) begin
                  r_cnt     <= r_cnt + 8'd1;
                  r_mem_req <= 1'b0;
                  r_cpu_err <= 1'b1;
                  r_state   <= StError;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            StError: begin
               r_cpu_err <= 1'b0;
               r_state   <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign bus.cpu_stall = (r_state == StCheck) || (r_state == StAccess) ||
                          ((r_state == StIdle) && w_req);
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.cpu_err   = r_cpu_err;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_be    = r_mem_be;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;

   a_word_addr : assert property (@(posedge clk) disable iff (!reset)
      r_mem_addr[1:0] == 2'b00);

   a_access_stable : assert property (@(posedge clk) disable iff (!reset)
      (r_state == StAccess && !bus.mem_ack && r_cnt != CntLast) |=>
      $stable({r_mem_req, r_mem_we, r_mem_be, r_mem_addr, r_mem_wdata}));

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: constant vector table, hand-written reset
// sequences, and randomized transactions against a behavioural model.
module tb_mem_interface;

   localparam int unsigned TO = 15;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mem_interface_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_interface #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic        swb;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack_at;  // ACCESS cycle (1-based) that gets the ack; 0 or >TO = never
      logic [31:0] rdat;
   } req_t;

   typedef struct {
      int          stall;
      int          req;
      int          err;
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      logic        stable;
      logic [31:0] rdata;
   } res_t;

   typedef struct {
      req_t i;
      res_t e;
   } vec_t;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] model_rdata;
   vec_t        tbl[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Outcome of one access computed from the rules, not from the RTL's state machine.
   function automatic res_t model(input req_t r);
      res_t e;
      bit   bad;
      bit   tmo;
      int   n;
      bad      = (r.rd && r.wr) || (r.wr && !r.swb && (r.addr % 4 != 0));
      e.stable = 1'b1;
      e.addr   = r.addr & ~32'h3;
      e.we     = r.wr;
      e.be     = 4'hF;
      e.wdata  = r.wdata;
      if (r.wr && r.swb) begin
         e.be    = 4'(1 << (r.addr % 4));
         e.wdata = 32'(r.wdata[7:0]) * 32'h0101_0101;
      end
      if (bad) begin
         e.stall = 2;
         e.req   = 0;
         e.err   = 1;
      end else begin
         tmo     = (r.ack_at < 1) || (r.ack_at > int'(TO));
         n       = tmo ? int'(TO) : r.ack_at;
         e.stall = 2 + n;
         e.req   = n;
         e.err   = tmo ? 1 : 0;
         if (r.rd && !tmo) model_rdata = r.rdat;
      end
      e.rdata = model_rdata;
      return e;
   endfunction

   // Called at a falling edge; plays both the CPU and the RAM, returns at a falling edge.
   task automatic run_txn(input req_t r, output res_t o);
      int acc;
      bit done;
      acc      = 0;
      done     = 1'b0;
      o.stall  = 0;
      o.req    = 0;
      o.err    = 0;
      o.addr   = '0;
      o.be     = '0;
      o.we     = 1'b0;
      o.wdata  = '0;
      o.stable = 1'b1;
      o.rdata  = '0;
      bus.cpu_read  = r.rd;
      bus.cpu_write = r.wr;
      bus.cpu_swb   = r.swb;
      bus.cpu_addr  = r.addr;
      bus.cpu_wdata = r.wdata;
      for (int c = 0; c < 60 && !done; c++) begin
         #1;
         if (bus.cpu_stall) o.stall++;
         if (bus.cpu_err) o.err++;
         if (bus.mem_req) begin
            acc++;
            o.req++;
            if (acc == 1) begin
               o.addr  = bus.mem_addr;
               o.be    = bus.mem_be;
               o.we    = bus.mem_we;
               o.wdata = bus.mem_wdata;
            end else if (o.addr !== bus.mem_addr || o.be !== bus.mem_be ||
                         o.we !== bus.mem_we || o.wdata !== bus.mem_wdata) begin
               o.stable = 1'b0;
            end
            bus.mem_ack   = (acc == r.ack_at);
            bus.mem_rdata = (acc == r.ack_at) ? r.rdat : $urandom();
         end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom();
         end
         if (!bus.cpu_stall) begin
            bus.cpu_read  = 1'b0;
            bus.cpu_write = 1'b0;
            done          = 1'b1;
         end
         @(negedge clk);
      end
      check("txn_bound", 32'(done), 32'd1);
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      // Trailing idle cycles, with a stray ack that must be ignored.
      for (int c = 0; c < 3; c++) begin
         #1;
         if (bus.cpu_stall) o.stall++;
         if (bus.cpu_err) o.err++;
         if (bus.mem_req) o.req++;
         bus.mem_ack   = (c == 0);
         bus.mem_rdata = $urandom();
         @(negedge clk);
      end
      bus.mem_ack = 1'b0;
      o.rdata     = bus.cpu_rdata;
   endtask

   task automatic compare(input string tag, input res_t a, input res_t e);
      check({tag, ".stall"}, 32'(a.stall), 32'(e.stall));
      check({tag, ".req_cycles"}, 32'(a.req), 32'(e.req));
      check({tag, ".err"}, 32'(a.err), 32'(e.err));
      check({tag, ".rdata"}, a.rdata, e.rdata);
      if (e.req > 0) begin
         check({tag, ".mem_addr"}, a.addr, e.addr);
         check({tag, ".mem_be"}, 32'(a.be), 32'(e.be));
         check({tag, ".mem_we"}, 32'(a.we), 32'(e.we));
         check({tag, ".stable"}, 32'(a.stable), 32'd1);
         if (e.we) check({tag, ".mem_wdata"}, a.wdata, e.wdata);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".mem_req"}, 32'(bus.mem_req), 32'd0);
      check({tag, ".mem_we"}, 32'(bus.mem_we), 32'd0);
      check({tag, ".mem_be"}, 32'(bus.mem_be), 32'd0);
      check({tag, ".mem_addr"}, bus.mem_addr, 32'd0);
      check({tag, ".mem_wdata"}, bus.mem_wdata, 32'd0);
      check({tag, ".cpu_rdata"}, bus.cpu_rdata, 32'd0);
      check({tag, ".cpu_err"}, 32'(bus.cpu_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t act;
      res_t exp;
      req_t r;
      int   ok;

      // rd wr swb addr wdata ack rdat | stall req err addr be we wdata stable rdata
      tbl[0]  = '{'{1, 0, 0, 32'h104, 32'h0, 2, 32'hDEADBEEF},
                  '{4, 2, 0, 32'h104, 4'hF, 0, 32'h0, 1, 32'hDEADBEEF}};
      tbl[1]  = '{'{0, 1, 1, 32'h203, 32'h123456A5, 1, 32'h0},
                  '{3, 1, 0, 32'h200, 4'h8, 1, 32'hA5A5A5A5, 1, 32'hDEADBEEF}};
      tbl[2]  = '{'{0, 1, 0, 32'h2, 32'hFFFF0000, 1, 32'h0},
                  '{2, 0, 1, 32'h0, 4'h0, 0, 32'h0, 1, 32'hDEADBEEF}};
      tbl[3]  = '{'{1, 1, 0, 32'h40, 32'h1, 1, 32'h0},
                  '{2, 0, 1, 32'h0, 4'h0, 0, 32'h0, 1, 32'hDEADBEEF}};
      tbl[4]  = '{'{1, 0, 0, 32'h107, 32'h0, 1, 32'h11223344},
                  '{3, 1, 0, 32'h104, 4'hF, 0, 32'h0, 1, 32'h11223344}};
      tbl[5]  = '{'{1, 0, 0, 32'h300, 32'h0, 0, 32'h99999999},
                  '{17, 15, 1, 32'h300, 4'hF, 0, 32'h0, 1, 32'h11223344}};
      tbl[6]  = '{'{1, 0, 0, 32'h400, 32'h0, 15, 32'hCAFEF00D},
                  '{17, 15, 0, 32'h400, 4'hF, 0, 32'h0, 1, 32'hCAFEF00D}};
      tbl[7]  = '{'{0, 1, 0, 32'h10, 32'h55AA55AA, 3, 32'h0},
                  '{5, 3, 0, 32'h10, 4'hF, 1, 32'h55AA55AA, 1, 32'hCAFEF00D}};
      tbl[8]  = '{'{0, 1, 1, 32'h11, 32'hABCDEF3C, 1, 32'h0},
                  '{3, 1, 0, 32'h10, 4'h2, 1, 32'h3C3C3C3C, 1, 32'hCAFEF00D}};
      tbl[9]  = '{'{0, 1, 1, 32'h20, 32'h00000077, 2, 32'h0},
                  '{4, 2, 0, 32'h20, 4'h1, 1, 32'h77777777, 1, 32'hCAFEF00D}};
      tbl[10] = '{'{0, 1, 0, 32'h80, 32'h0BADF00D, 0, 32'h0},
                  '{17, 15, 1, 32'h80, 4'hF, 1, 32'h0BADF00D, 1, 32'hCAFEF00D}};

      reset         = 1'b0;
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
      bus.cpu_swb   = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.mem_rdata = '0;
      bus.mem_ack   = 1'b0;
      model_rdata   = '0;

      // Reset state, during and after reset with no request.
      repeat (2) @(negedge clk);
      check_reset_outputs("rst_hold");
      check("rst_hold.stall", 32'(bus.cpu_stall), 32'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("post_rst");
      check("post_rst.stall", 32'(bus.cpu_stall), 32'd0);

      for (int k = 0; k < 11; k++) begin
         run_txn(tbl[k].i, act);
         compare($sformatf("tbl%0d", k), act, tbl[k].e);
         model_rdata = tbl[k].e.rdata;
      end

      // Reset asserted in the middle of ACCESS must drop mem_req without a clock edge.
      bus.cpu_read  = 1'b1;
      bus.cpu_addr  = 32'h500;
      bus.cpu_wdata = 32'h13579BDF;
      ok = 0;
      for (int c = 0; c < 10 && ok == 0; c++) begin
         @(negedge clk);
         if (bus.mem_req) ok = 1;
      end
      check("midrst.req_seen", 32'(bus.mem_req), 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      bus.cpu_read  = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      model_rdata = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("post_midrst");
      r = '{1, 0, 0, 32'h504, 32'h0, 1, 32'h600DCAFE};
      run_txn(r, act);
      exp = model(r);
      compare("after_rst", act, exp);

      // Randomized accesses against the behavioural model.
      for (int k = 0; k < 40; k++) begin
         r.rd    = $urandom_range(0, 1);
         r.wr    = $urandom_range(0, 1);
         if (!r.rd && !r.wr) r.rd = 1'b1;
         r.swb   = $urandom_range(0, 1);
         r.addr  = $urandom();
         if ($urandom_range(0, 1) == 1) r.addr[1:0] = 2'b00;
         r.wdata = $urandom();
         r.rdat  = $urandom();
         r.ack_at = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, 4))
                                                : int'($urandom_range(0, 17));
         run_txn(r, act);
         exp = model(r);
         compare($sformatf("rnd%0d", k), act, exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
